vvp: RTL and testbench

//  Vector-vector dot product of one n-bit weight row W with an n-element 2-bit data vector D.

---
 rtl/mvu_pkg.sv | 57 +++++
 rtl/vvp_addtree.sv | 76 +++++++
 rtl/vvp.sv | 42 ++++
 tb/tb_vvp.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// Shared definitions for the matrix-vector unit: mode and ternary data encodings,
// plus the per-element product used by every vvp leaf.
package mvu_pkg;

  typedef enum logic [1:0] {
    MODE_BIPTERN = 2'b00,
    MODE_UNITERN = 2'b01,
    MODE_XNOR    = 2'b10,
    MODE_AND     = 2'b11
  } mode_e;

  localparam logic [1:0] D_ZERO = 2'b00;
  localparam logic [1:0] D_POS  = 2'b01;
  localparam logic [1:0] D_NEG  = 2'b11;

  localparam logic [1:0] P_ZERO = 2'b00;
  localparam logic [1:0] P_POS  = 2'b01;
  localparam logic [1:0] P_NEG  = 2'b11;

  // Product of one weight bit and one data code as a 2-bit signed value in {-1,0,+1}.
  function automatic logic [1:0] elem_prod(input mode_e mode, input logic w, input logic [1:0] d);
    logic w_nz;
    logic w_neg;
    logic d_nz;
    logic d_neg;
    w_nz  = 1'b1;
    w_neg = 1'b0;
    d_nz  = 1'b0;
    d_neg = 1'b0;
    case (mode)
      MODE_BIPTERN: begin
        w_neg = ~w;
        d_nz  = (d == D_POS) || (d == D_NEG);
        d_neg = (d == D_NEG);
      end
      MODE_UNITERN: begin
        w_nz  = w;
        d_nz  = (d == D_POS) || (d == D_NEG);
        d_neg = (d == D_NEG);
      end
      MODE_XNOR: begin
        w_neg = ~w;
        d_nz  = 1'b1;
        d_neg = ~d[0];
      end
      default: begin
        w_nz = w;
        d_nz = d[0];
      end
    endcase
    if (!(w_nz && d_nz)) begin
      return P_ZERO;
    end
    return (w_neg ^ d_neg) ? P_NEG : P_POS;
  endfunction

endpackage

// File: rtl/vvp_addtree.sv
// Balanced signed adder tree over n 2-bit products; pr register stages spread over the
// cut points (after products and after each level), with extra stages biased to the narrow end.
module vvp_addtree #(
  parameter int unsigned n  = 64,
  parameter int unsigned pr = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*n-1:0]         prod,
  output logic [$clog2(n)+1:0]   sum
);

  localparam int unsigned A    = $clog2(n);
  localparam int unsigned CUTS = A + 1;

  for (genvar j = 0; j <= A; j++) begin : g_lvl
    localparam int unsigned NE = n >> j;
    localparam int unsigned WD = j + 2;
    localparam int unsigned NR = pr / CUTS + ((j >= CUTS - pr % CUTS) ? 1 : 0);

    logic [NE*WD-1:0] sum_c;
    logic [NE*WD-1:0] lvl_out;

    if (j == 0) begin : g_leaf
      assign sum_c = prod;
    end else begin : g_add
      logic [2*NE*(WD-1)-1:0] prev;
      assign prev = g_lvl[j-1].lvl_out;

      // Pairwise sign-extended add, one bit wider than the level below.
      always_comb begin
        sum_c = '0;
        for (int k = 0; k < NE; k++) begin
          sum_c[k*WD +: WD] = WD'($signed(prev[(2*k)*(WD-1) +: WD-1]))
                            + WD'($signed(prev[(2*k+1)*(WD-1) +: WD-1]));
        end
      end
    end

    if (NR == 0) begin : g_comb
      assign lvl_out = sum_c;
    end else begin : g_pipe
      logic [NE*WD-1:0] pipe_d [NR];
      logic [NE*WD-1:0] pipe_q [NR];

      always_comb begin
        pipe_d[0] = sum_c;
        for (int r = 1; r < NR; r++) begin
          pipe_d[r] = pipe_q[r-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int r = 0; r < NR; r++) begin
            pipe_q[r] <= '0;
          end
        end else begin
          for (int r = 0; r < NR; r++) begin
            pipe_q[r] <= pipe_d[r];
          end
        end
      end

      assign lvl_out = pipe_q[NR-1];
    end
  end

  if (pr == 0) begin : g_nopipe
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end

  assign sum = g_lvl[A].lvl_out;

endmodule

// File: rtl/vvp.sv
// Vector-vector dot product of a 1-bit weight row with a 2-bit data vector,
// one leaf of the matrix-vector product array.
module vvp
  import mvu_pkg::*;
#(
  parameter int unsigned n  = 64,
  parameter int unsigned pr = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [n-1:0]         W,
  input  logic [2*n-1:0]       D,
  output logic [$clog2(n)+1:0] S
);

  localparam int unsigned a = $clog2(n);

  logic [2*n-1:0] prod_c;
  logic [a+1:0]   sum;

  // Products are formed before any register so mode travels with its W/D sample.
  always_comb begin
    prod_c = '0;
    for (int i = 0; i < n; i++) begin
      prod_c[2*i +: 2] = elem_prod(mode_e'(mode), W[i], D[2*i +: 2]);
    end
  end

  vvp_addtree #(
    .n  (n),
    .pr (pr)
  ) u_addtree (
    .clk   (clk),
    .rst_n (rst_n),
    .prod  (prod_c),
    .sum   (sum)
  );

  assign S = sum;

endmodule

// File: tb/tb_vvp.sv
// Bench for vvp: a combinational instance and a 2-stage pipelined instance share stimulus
// and are checked against an integer dot-product model.
module tb_vvp;

  localparam int unsigned N  = 64;
  localparam int unsigned SW = $clog2(N) + 2;

  logic            clk;
  logic            rst_n;
  logic [1:0]      mode;
  logic [N-1:0]    W;
  logic [2*N-1:0]  D;
  logic [SW-1:0]   S0;
  logic [SW-1:0]   S2;

  int n_pass;
  int n_total;
  int exp_q[$];

  vvp #(.n(N), .pr(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .W(W), .D(D), .S(S0)
  );

  vvp #(.n(N), .pr(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .W(W), .D(D), .S(S2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_dot(input logic [1:0] m, input logic [N-1:0] w, input logic [2*N-1:0] d);
    int s;
    int wv;
    int dv;
    logic [1:0] de;
    s = 0;
    for (int i = 0; i < N; i++) begin
      de = d[2*i +: 2];
      if (m == 2'b00 || m == 2'b10) wv = w[i] ? 1 : -1;
      else                          wv = w[i] ? 1 : 0;
      case (m)
        2'b10:   dv = de[0] ? 1 : -1;
        2'b11:   dv = de[0] ? 1 : 0;
        default: dv = (de == 2'b01) ? 1 : ((de == 2'b11) ? -1 : 0);
      endcase
      s += wv * dv;
    end
    return s;
  endfunction

  function automatic logic [2*N-1:0] rep_d(input logic [1:0] code);
    logic [2*N-1:0] v;
    for (int i = 0; i < N; i++) v[2*i +: 2] = code;
    return v;
  endfunction

  task automatic rand_inputs();
    mode = 2'($urandom_range(0, 3));
    W    = {$urandom, $urandom};
    D    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic chk_s0(input string name, input int e);
    n_total++;
    if (S0 !== SW'(e)) $display("FAIL %s: S=%0d expected %0d", name, $signed(S0), e);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode  = 2'b00;
    W     = '0;
    D     = '0;
    #3;
    n_total++;
    if (S2 !== '0) $display("FAIL reset_s2: S=%0d expected 0", $signed(S2));
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (S2 !== '0) $display("FAIL reset_hold: S=%0d expected 0", $signed(S2));
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    mode = 2'b00; W = '0; D = rep_d(2'b01); #1;
    chk_s0("bip_w0_dpos", -64);
    W = '1; D = rep_d(2'b11); #1;
    chk_s0("bip_w1_dneg", -64);
    D = rep_d(2'b01); #1;
    chk_s0("bip_w1_dpos", 64);
    D = rep_d(2'b10); #1;
    chk_s0("bip_reserved", 0);
    mode = 2'b01; W = {(N/2){2'b01}}; D = rep_d(2'b01); #1;
    chk_s0("uni_alt_dpos", 32);
    D = rep_d(2'b10); #1;
    chk_s0("uni_alt_drsv", 0);
    mode = 2'b10;
    for (int t = 0; t < 3; t++) begin
      D = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < N; i++) W[i] = D[2*i];
      #1;
      chk_s0("xnor_match", 64);
      W = ~W; #1;
      chk_s0("xnor_inv", -64);
    end
    mode = 2'b11; W = '1;
    D = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < N; i++) D[2*i] = (i < 10);
    #1;
    chk_s0("and_ten", 10);
  endtask

  task automatic run_stream(input int cycles);
    int e;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        n_total++;
        if (S2 !== SW'(e)) $display("FAIL pipe_s2: S=%0d expected %0d", $signed(S2), e);
        else n_pass++;
      end
      rand_inputs();
      exp_q.push_back(ref_dot(mode, W, D));
      #1;
      chk_s0("stream_s0", ref_dot(mode, W, D));
    end
  endtask

  task automatic test_stream();
    exp_q = {};
    run_stream(200);
  endtask

  task automatic test_reset_mid();
    run_stream(10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (S2 !== '0) $display("FAIL mid_reset_async: S=%0d expected 0", $signed(S2));
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (S2 !== '0) $display("FAIL mid_reset_hold: S=%0d expected 0", $signed(S2));
    else n_pass++;
    mode = 2'b00; W = '1; D = rep_d(2'b01);
    #1 rst_n = 1'b1;
    exp_q = {};
    exp_q.push_back(64);
    @(negedge clk);
    n_total++;
    if (S2 !== '0) $display("FAIL post_reset_edge1: S=%0d expected 0", $signed(S2));
    else n_pass++;
    rand_inputs();
    exp_q.push_back(ref_dot(mode, W, D));
    run_stream(20);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_directed();
    test_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
